// File: rtl/enc_code_fifo.sv
// enc_code_fifo: first-word-fall-through FIFO of 2-bit codes from a 4-to-2 encoder.
// Define ENC_CODE_FIFO_OVF_EN to enable the sticky overflow flag on dropped pushes.
module enc_code_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     a1,
    input  logic                     a0,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_code,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // Status depends only on stored count, so full/empty never see in_valid or out_ready.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign count     = count_q;
    assign out_code  = empty ? 2'b00 : mem_q[rd_ptr_q];

    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers and count discards its contents.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= {a1, a0};
    end

`ifdef ENC_CODE_FIFO_OVF_EN
    logic ovf_q;
    logic drop;

    assign drop = in_valid & full & ~pop;
    assign ovf  = ovf_q;

    always_ff @(posedge clk) begin
        if (rst)       ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_enc_code_fifo.sv
// Self-checking bench for enc_code_fifo: queue model compared every cycle plus directed literals.
module tb_enc_code_fifo;

    localparam int DEPTH = 4;
`ifdef ENC_CODE_FIFO_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       a1;
    logic       a0;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;

    enc_code_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a1        (a1),
        .a0        (a0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Behavioural model: an ordered queue of codes plus a sticky overflow bit.
    logic [1:0] model_q[$];
    bit         model_ovf = 1'b0;

    always @(posedge clk) begin
        bit         m_pop;
        bit         m_push;
        logic [1:0] discard;
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            m_pop  = (model_q.size() > 0) && (out_ready === 1'b1);
            m_push = (in_valid === 1'b1) && ((model_q.size() < DEPTH) || m_pop);
            if (m_pop) discard = model_q.pop_front();
            if (m_push) model_q.push_back({a1, a0});
            if ((in_valid === 1'b1) && !m_push && OVF_EN) model_ovf = 1'b1;
        end
    end

    always @(negedge clk) begin
        int sz;
        sz = model_q.size();
        check("count",     int'(count),     sz);
        check("empty",     int'(empty),     int'(sz == 0));
        check("full",      int'(full),      int'(sz == DEPTH));
        check("out_valid", int'(out_valid), int'(sz != 0));
        check("out_code",  int'(out_code),  (sz != 0) ? int'(model_q[0]) : 0);
        check("ovf",       int'(ovf),       int'(model_ovf));
    end

    // Drive one cycle of inputs and return at the following falling edge.
    task automatic step(input logic iv, input logic [1:0] code, input logic rdy);
        in_valid  = iv;
        {a1, a0}  = code;
        out_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_seq [4];

        rst = 1'b1; in_valid = 1'b0; a1 = 1'b0; a0 = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        step(1'b1, 2'd3, 1'b1);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full",  int'(full), 0);
        check("rst_code",  int'(out_code), 0);
        check("rst_ovf",   int'(ovf), 0);
        rst = 1'b0;

        // Fill with 3,2,1,0 and hold the output.
        step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd2, 1'b0);
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd0, 1'b0);
        check("fill_count", int'(count), 4);
        check("fill_full",  int'(full), 1);
        check("fill_code",  int'(out_code), 3);

        // Push into a full FIFO without pop: dropped.
        step(1'b1, 2'd1, 1'b0);
        check("drop_count", int'(count), 4);
        check("drop_code",  int'(out_code), 3);
        check("drop_ovf",   int'(ovf), int'(OVF_EN));

        // Push+pop while full: 3 leaves, 2 enters at the tail.
        step(1'b1, 2'd2, 1'b1);
        check("pp_full_count", int'(count), 4);
        check("pp_full_code",  int'(out_code), 2);

        exp_seq = '{2'd2, 2'd1, 2'd0, 2'd2};
        for (int i = 0; i < 4; i++) begin
            check("drain1_code", int'(out_code), int'(exp_seq[i]));
            step(1'b0, 2'd0, 1'b1);
        end
        check("drain1_empty", int'(empty), 1);
        check("drain1_code0", int'(out_code), 0);

        // Refill and drain with in_valid low: 3,2,1,0 in order, pointers wrap.
        for (int i = 3; i >= 0; i--) step(1'b1, 2'(i), 1'b0);
        exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) begin
            check("drain2_code", int'(out_code), int'(exp_seq[i]));
            step(1'b0, 2'd0, 1'b1);
        end
        check("drain2_empty", int'(empty), 1);

        // out_ready while empty has no effect.
        step(1'b0, 2'd0, 1'b1);
        check("empty_rdy_count", int'(count), 0);

        // No same-cycle bypass: code 2 shows up one cycle after the push.
        in_valid = 1'b1; {a1, a0} = 2'd2; out_ready = 1'b0;
        #1 check("nobypass_valid", int'(out_valid), 0);
        @(negedge clk);
        check("push_valid", int'(out_valid), 1);
        check("push_code",  int'(out_code), 2);

        // Push+pop at count 1: the new entry replaces the head.
        step(1'b1, 2'd1, 1'b1);
        check("pp1_count", int'(count), 1);
        check("pp1_code",  int'(out_code), 1);
        for (int i = 0; i < 10; i++) step(1'b1, 2'(i), 1'b1);
        check("stream_count", int'(count), 1);
        check("stream_code",  int'(out_code), 1);

        // Fill, overflow, then pop down to two entries before reset.
        step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd2, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        step(1'b0, 2'd0, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        check("pre_rst_count", int'(count), 2);
        check("pre_rst_ovf",   int'(ovf), int'(OVF_EN));

        rst = 1'b1;
        step(1'b1, 2'd3, 1'b1);
        rst = 1'b0;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_ovf",   int'(ovf), 0);
        step(1'b1, 2'd1, 1'b0);
        check("post_rst_code", int'(out_code), 1);
        step(1'b0, 2'd0, 1'b1);
        check("post_rst_empty", int'(empty), 1);

        step(1'b0, 2'd0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_code_fifo.md
ENC_CODE_FIFO -- requirements
Module: enc_code_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of 2-bit code entries; SHALL be a power of two, 2..16.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 Port: in_valid  input  1  upstream 4-to-2 encoder code valid (at least one request line asserted).
REQ-005 Port: a1  input  1  encoded code MSB from the 4-to-2 encoder.
REQ-006 Port: a0  input  1  encoded code LSB from the 4-to-2 encoder.
REQ-007 Port: out_valid  output  1  head entry available.
REQ-008 Port: out_ready  input  1  downstream accepts the head entry.
REQ-009 Port: out_code  output  2  head entry code, {a1,a0} order.
REQ-010 Port: count  output  log2(DEPTH)+1  number of stored entries.
REQ-011 Port: full  output  1  count == DEPTH.
REQ-012 Port: empty  output  1  count == 0.
REQ-013 Port: ovf  output  1  sticky overflow flag.

Function
REQ-014 Push SHALL occur when in_valid=1 and (full=0 or pop=1 in the same cycle); the stored value SHALL be {a1,a0}.
REQ-015 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-016 Storage SHALL be first-word-fall-through: out_code SHALL equal the oldest entry whenever out_valid=1.
REQ-017 A code pushed in cycle N SHALL first be visible on out_code/out_valid in cycle N+1; no same-cycle bypass.
REQ-018 out_valid SHALL equal ~empty; out_code SHALL be 2'b00 whenever empty=1.
REQ-019 count SHALL increment on push-only, decrement on pop-only, hold on push+pop or neither.
REQ-020 Read and write pointers SHALL wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-021 Push+pop when full SHALL accept the new entry and keep count == DEPTH; order SHALL be preserved.
REQ-022 Push+pop when count == 1 SHALL present the new entry at cycle N+1 with count == 1.
REQ-023 in_valid=1 with full=1 and no pop SHALL drop the input; contents and count SHALL be unchanged.
REQ-024 out_ready while empty SHALL have no effect.
REQ-025 full and empty SHALL be registered-state-derived with no combinational path from in_valid or out_ready.

Reset
REQ-026 While rst=1: pointers=0, count=0, empty=1, full=0, out_valid=0, out_code=2'b00, ovf=0.
REQ-027 rst SHALL take priority over push and pop; in_valid and out_ready SHALL be ignored in reset cycles.
REQ-028 Reset mid-operation SHALL discard all stored entries; storage array itself need not be cleared.

Configuration
REQ-029 Macro ENC_CODE_FIFO_OVF_EN: when defined, ovf SHALL set to 1 in the cycle after a dropped push (REQ-023) and remain 1 until rst.
REQ-030 Without ENC_CODE_FIFO_OVF_EN, the ovf port SHALL remain present and be driven constant 0; all other behaviour identical.

Verification
REQ-031 Reset then push codes 3,2,1,0 on consecutive cycles, out_ready=0 -> count=4, full=1, out_code=3.
REQ-032 From full, out_ready=1 for 4 cycles, in_valid=0 -> out_code sequence 3,2,1,0, then empty=1, out_code=2'b00.
REQ-033 Full, push code 1 with out_ready=0 -> input dropped, count=4, ovf=1 next cycle (macro defined) / ovf=0 (undefined).
REQ-034 Full with in_valid=1 code 2 and out_ready=1 -> count stays 4, code 2 appears as 4th pop later.
REQ-035 Empty, push code 2 in cycle N -> out_valid=0 in N, out_valid=1 and out_code=2 in N+1.
REQ-036 Two entries stored, ovf=1, assert rst one cycle -> count=0, empty=1, ovf=0, subsequent push of code 1 pops as 1.
